// File: rtl/matrix_mult_sched.sv
// rtl/matrix_mult_sched.sv - round-robin scheduler sharing one matrix_mult unit among requesters
module matrix_mult_sched #(
    parameter int NUM_REQ  = 2,
    parameter int MIN_WAIT = 1,
    parameter int MAX_WAIT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*256-1:0]   req_m1,
    input  logic [NUM_REQ*256-1:0]   req_m2,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [1:0]               rsp_id,
    output logic                     rsp_err,
    output logic [255:0]             rsp_data,
    output logic [255:0]             mm_m1,
    output logic [255:0]             mm_m2,
    output logic                     mm_enable,
    input  logic                     mm_done,
    input  logic [255:0]             mm_result,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [1:0]     rr_ptr;
    logic [1:0]     id;
    logic [1:0]     win;
    logic           found;
    logic [2:0]     idx;
    logic [3:0]     valid_pad;
    logic [3:0]     grant_pad;
    logic [1023:0]  m1_pad;
    logic [1023:0]  m2_pad;
    logic [7:0]     cnt;
    logic [7:0]     cnt_inc;
    logic           done_ok;
    logic           timeout;

    // Padding to four slots keeps every select in range for any legal NUM_REQ.
    assign valid_pad = 4'(req_valid);
    assign m1_pad    = 1024'(req_m1);
    assign m2_pad    = 1024'(req_m2);

    always_comb begin
        found     = 1'b0;
        win       = 2'd0;
        idx       = 3'd0;
        grant_pad = 4'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + 3'(k);
            if (idx >= 3'(NUM_REQ)) begin
                idx = idx - 3'(NUM_REQ);
            end
            if (!found && valid_pad[idx[1:0]]) begin
                found = 1'b1;
                win   = idx[1:0];
            end
        end
        if (state == S_IDLE && !reset && found) begin
            grant_pad[win] = 1'b1;
        end
    end

    assign req_ready = grant_pad[NUM_REQ-1:0];

    // The compare uses the post-increment count so the first WAIT cycle counts as 1.
    assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    assign done_ok = mm_done && (cnt_inc >= 8'(MIN_WAIT));
    assign timeout = (cnt_inc == 8'(MAX_WAIT));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (found) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (done_ok || timeout) state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            rr_ptr   <= 2'd0;
            cnt      <= 8'd0;
            id       <= 2'd0;
            mm_m1    <= '0;
            mm_m2    <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        mm_m1 <= m1_pad[{win, 8'd0} +: 256];
                        mm_m2 <= m2_pad[{win, 8'd0} +: 256];
                        id    <= win;
                    end
                end
                S_ISSUE: cnt <= 8'd0;
                S_WAIT: begin
                    cnt <= cnt_inc;
                    if (done_ok) begin
                        rsp_data <= mm_result;
                        rsp_err  <= 1'b0;
                    end else if (timeout) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rr_ptr <= (id == 2'(NUM_REQ - 1)) ? 2'd0 : id + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mm_enable = (state == S_ISSUE);
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);
    assign rsp_id    = id;

endmodule

// File: tb/tb_matrix_mult_sched.sv
// tb/tb_matrix_mult_sched.sv - directed self-checking bench for matrix_mult_sched
module tb_matrix_mult_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [1:0]    req_valid;
    logic [511:0]  req_m1, req_m2;
    logic [1:0]    req_ready;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [1:0]    rsp_id;
    logic [255:0]  rsp_data, mm_m1, mm_m2, mm_result;
    logic          mm_enable, mm_done, busy;

    logic          b_req_valid, b_req_ready;
    logic [255:0]  b_req_m1, b_req_m2;
    logic          b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [1:0]    b_rsp_id;
    logic [255:0]  b_rsp_data, b_mm_m1, b_mm_m2, b_mm_result;
    logic          b_mm_enable, b_mm_done, b_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n;

    logic [255:0] ident, ident2, elems, elems2, elems3;

    matrix_mult_sched #(.NUM_REQ(2), .MIN_WAIT(1), .MAX_WAIT(15)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_m1(req_m1), .req_m2(req_m2), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_data(rsp_data), .mm_m1(mm_m1), .mm_m2(mm_m2), .mm_enable(mm_enable),
        .mm_done(mm_done), .mm_result(mm_result), .busy(busy)
    );

    matrix_mult_sched #(.NUM_REQ(1), .MIN_WAIT(3), .MAX_WAIT(15)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_m1(b_req_m1), .req_m2(b_req_m2), .req_ready(b_req_ready),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id), .rsp_err(b_rsp_err),
        .rsp_data(b_rsp_data), .mm_m1(b_mm_m1), .mm_m2(b_mm_m2), .mm_enable(b_mm_enable),
        .mm_done(b_mm_done), .mm_result(b_mm_result), .busy(b_busy)
    );

    // External unit model: 4x4 matrix of 16-bit elements, element r*4+c at [(r*4+c)*16 +: 16].
    function automatic logic [255:0] matmul(input logic [255:0] a, input logic [255:0] b);
        logic [255:0] res = '0;
        logic [15:0]  sum;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sum = '0;
                for (int k = 0; k < 4; k++) begin
                    sum = sum + a[(r*4+k)*16 +: 16] * b[(k*4+c)*16 +: 16];
                end
                res[(r*4+c)*16 +: 16] = sum;
            end
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input int exp_id, input logic [255:0] exp_m1,
                          input logic [255:0] exp_data, input logic [1:0] raise, input int hold);
        logic [255:0] d0;
        #1;
        chk({tag, " ready"}, 256'(req_ready), 256'(2'b01 << exp_id));
        tick;
        req_valid[exp_id] = 1'b0;
        req_valid = req_valid | raise;
        chk({tag, " enable"}, 256'(mm_enable), 256'(1));
        chk({tag, " m1"}, mm_m1, exp_m1);
        tick;
        chk({tag, " early valid"}, 256'(rsp_valid), 256'(0));
        mm_done   = 1'b1;
        mm_result = matmul(mm_m1, mm_m2);
        tick;
        mm_done   = 1'b0;
        mm_result = '0;
        chk({tag, " valid"}, 256'(rsp_valid), 256'(1));
        chk({tag, " id"}, 256'(rsp_id), 256'(exp_id));
        chk({tag, " err"}, 256'(rsp_err), 256'(0));
        chk({tag, " data"}, rsp_data, exp_data);
        d0 = exp_data;
        for (int i = 0; i < hold; i++) begin
            tick;
            chk({tag, " hold valid"}, 256'(rsp_valid), 256'(1));
            chk({tag, " hold data"}, rsp_data, d0);
            chk({tag, " hold id"}, 256'(rsp_id), 256'(exp_id));
            chk({tag, " hold ready"}, 256'(req_ready), 256'(0));
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk({tag, " idle"}, 256'(busy), 256'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        ident = '0; ident2 = '0; elems = '0; elems2 = '0; elems3 = '0;
        for (int k = 0; k < 16; k++) begin
            elems[k*16 +: 16]  = 16'(k + 1);
            elems2[k*16 +: 16] = 16'(2 * (k + 1));
            elems3[k*16 +: 16] = 16'(3 * (k + 1));
            if (k % 5 == 0) begin
                ident[k*16 +: 16]  = 16'd1;
                ident2[k*16 +: 16] = 16'd2;
            end
        end
        reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
        req_m1 = {ident2, ident}; req_m2 = {elems, elems};
        mm_done = 1'b0; mm_result = '0;
        b_req_valid = 1'b0; b_req_m1 = ident; b_req_m2 = elems;
        b_rsp_ready = 1'b0; b_mm_done = 1'b1; b_mm_result = elems3;

        tick; tick;
        chk("rst rsp_valid", 256'(rsp_valid), 256'(0));
        chk("rst busy", 256'(busy), 256'(0));
        chk("rst enable", 256'(mm_enable), 256'(0));
        chk("rst ready", 256'(req_ready), 256'(0));
        chk("rst data", rsp_data, 256'(0));
        chk("rst m1", mm_m1, 256'(0));
        reset = 1'b0;

        // 1: identity times 1..16
        req_valid = 2'b01;
        run_op("t1", 0, ident, elems, 2'b00, 0);

        // 2: simultaneous requests at reset exit, then round-robin past req0
        reset = 1'b1; req_valid = 2'b11;
        tick; tick;
        reset = 1'b0;
        run_op("t2a", 0, ident, elems, 2'b00, 0);
        run_op("t2b", 1, ident2, elems2, 2'b01, 0);
        run_op("t2c", 0, ident, elems, 2'b00, 0);

        // 3: response back-pressure with a pending request
        req_valid = 2'b10;
        run_op("t3a", 1, ident2, elems2, 2'b01, 10);
        run_op("t3b", 0, ident, elems, 2'b00, 0);

        // 4: watchdog expiry, then done exactly at the final count
        req_valid = 2'b01;
        #1;
        chk("t4 ready", 256'(req_ready), 256'(1));
        tick;
        req_valid = 2'b00;
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick;
            n++;
        end
        chk("t4 wd latency", 256'(n), 256'(16));
        chk("t4 wd err", 256'(rsp_err), 256'(1));
        chk("t4 wd data", rsp_data, 256'(0));
        rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
        req_valid = 2'b01;
        tick;
        req_valid = 2'b00;
        for (int i = 0; i < 15; i++) tick;
        chk("t4 edge pre", 256'(rsp_valid), 256'(0));
        mm_done = 1'b1; mm_result = matmul(mm_m1, mm_m2);
        tick;
        mm_done = 1'b0; mm_result = '0;
        chk("t4 edge valid", 256'(rsp_valid), 256'(1));
        chk("t4 edge err", 256'(rsp_err), 256'(0));
        chk("t4 edge data", rsp_data, elems);
        rsp_ready = 1'b1; tick; rsp_ready = 1'b0;

        // 5: reset in WAIT drops the operation and restores rr_ptr
        req_valid = 2'b01;
        tick;
        req_valid = 2'b00;
        tick; tick;
        reset = 1'b1;
        tick;
        chk("t5 valid", 256'(rsp_valid), 256'(0));
        chk("t5 busy", 256'(busy), 256'(0));
        chk("t5 enable", 256'(mm_enable), 256'(0));
        chk("t5 m1", mm_m1, 256'(0));
        chk("t5 m2", mm_m2, 256'(0));
        chk("t5 data", rsp_data, 256'(0));
        chk("t5 err", 256'(rsp_err), 256'(0));
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("t5 no rsp", 256'({rsp_valid, busy}), 256'(0));
        end
        req_valid = 2'b11;
        run_op("t5", 0, ident, elems, 2'b00, 0);
        req_valid = 2'b00;

        // 6: stale done ignored until the third WAIT cycle
        b_req_valid = 1'b1;
        #1;
        chk("t6 ready", 256'(b_req_ready), 256'(1));
        tick;
        b_req_valid = 1'b0;
        chk("t6 enable", 256'(b_mm_enable), 256'(1));
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("t6 early valid", 256'(b_rsp_valid), 256'(0));
        end
        b_mm_result = elems;
        tick;
        chk("t6 valid", 256'(b_rsp_valid), 256'(1));
        chk("t6 data", b_rsp_data, elems);
        chk("t6 id", 256'(b_rsp_id), 256'(0));
        chk("t6 err", 256'(b_rsp_err), 256'(0));
        b_rsp_ready = 1'b1; tick; b_rsp_ready = 1'b0;
        chk("t6 idle", 256'(b_busy), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
